// File: rtl/prog_chan_sequencer_if.sv
// prog_chan_sequencer_if: command-side and channel-side signals of the programmer sequencer.
`default_nettype none

interface prog_chan_sequencer_if;
  logic       cfg_req;
  logic       cfg_abort;
  logic [4:0] chan_mask;
  logic [4:0] prog_done;
  logic       prog_reset;
  logic       prog_start;
  logic       busy;
  logic       cfg_done;
  logic       cfg_error;
  logic [1:0] retry_count;
  logic [4:0] fail_mask;

  modport master (
    output cfg_req, cfg_abort, chan_mask, prog_done,
    input  prog_reset, prog_start, busy, cfg_done, cfg_error, retry_count, fail_mask
  );

  modport slave (
    input  cfg_req, cfg_abort, chan_mask, prog_done,
    output prog_reset, prog_start, busy, cfg_done, cfg_error, retry_count, fail_mask
  );
endinterface

`default_nettype wire

// File: rtl/prog_chan_sequencer.sv
// +--------------------------------------------------------------------------+
// | prog_chan_sequencer: reset/start/timeout/retry supervisor for the        |
// | five-channel programmer. Optional PROG_SEQ_AUTOSTART_EN starts one full  |
// | sequence after reset. Rev 1.0                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module prog_chan_sequencer #(
  parameter int unsigned RESET_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  prog_chan_sequencer_if.slave  bus
);

  localparam logic [31:0] RST_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [4:0]  mask_q, mask_d;
  logic [1:0]  retry_q, retry_d;
  logic [4:0]  fail_q, fail_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        prog_reset_q, prog_start_q, busy_q;
  logic [4:0]  done_meta, done_s;
  logic        all_done;
  logic        auto_go;
  logic        req_go;
  logic [4:0]  req_mask;

`ifdef PROG_SEQ_AUTOSTART_EN
  // Set by reset, consumed on the first clock after reset_n releases.
  logic auto_pend;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) auto_pend <= 1'b1;
    else          auto_pend <= 1'b0;
  end
  assign auto_go = auto_pend;
`else
  assign auto_go = 1'b0;
`endif

  assign req_go   = bus.cfg_req | auto_go;
  assign req_mask = auto_go ? 5'h1F : bus.chan_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_meta <= 5'd0;
      done_s    <= 5'd0;
    end else begin
      done_meta <= bus.prog_done;
      done_s    <= done_meta;
    end
  end

  assign all_done = &(done_s | ~mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 32'd0;
      mask_q       <= 5'd0;
      retry_q      <= 2'd0;
      fail_q       <= 5'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      prog_reset_q <= 1'b1;
      prog_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      retry_q      <= retry_d;
      fail_q       <= fail_d;
      done_q       <= done_d;
      err_q        <= err_d;
      prog_reset_q <= (state_d == S_IDLE) || (state_d == S_RST) || (state_d == S_FAIL);
      prog_start_q <= (state_d == S_START);
      busy_q       <= (state_d == S_RST) || (state_d == S_START) || (state_d == S_WAIT);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    retry_d = retry_q;
    fail_d  = fail_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        // Abort beats a simultaneous request, even outside a sequence.
        if (req_go && !bus.cfg_abort) begin
          mask_d  = req_mask;
          retry_d = 2'd0;
          fail_d  = 5'd0;
          err_d   = 1'b0;
          if (req_mask == 5'd0) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            done_d  = 1'b0;
            cnt_d   = RST_LAST;
            state_d = S_RST;
          end
        end
      end
      S_RST: begin
        if (bus.cfg_abort)        state_d = S_IDLE;
        else if (cnt_q == 32'd0)  state_d = S_START;
        else                      cnt_d   = cnt_q - 32'd1;
      end
      S_START: begin
        if (bus.cfg_abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = 32'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.cfg_abort) begin
          state_d = S_IDLE;
        end else if (all_done) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            cnt_d   = RST_LAST;
            state_d = S_RST;
          end else begin
            fail_d  = mask_q & ~done_s;
            err_d   = 1'b1;
            state_d = S_FAIL;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.prog_reset  = prog_reset_q;
  assign bus.prog_start  = prog_start_q;
  assign bus.busy        = busy_q;
  assign bus.cfg_done    = done_q;
  assign bus.cfg_error   = err_q;
  assign bus.retry_count = retry_q;
  assign bus.fail_mask   = fail_q;

endmodule

`default_nettype wire
